// File: rtl/pc_sched_pkg.sv
// pc_sched_pkg: next-PC select codes, FSM states and the output bundle
// shared by the fetch-stage PC scheduler and its mult/div counter.
package pc_sched_pkg;

  localparam logic [2:0] PC_SEL_J    = 3'd0;
  localparam logic [2:0] PC_SEL_JR   = 3'd1;
  localparam logic [2:0] PC_SEL_NPC  = 3'd2;
  localparam logic [2:0] PC_SEL_VEC  = 3'd3;
  localparam logic [2:0] PC_SEL_BR   = 3'd4;
  localparam logic [2:0] PC_SEL_ERET = 3'd5;

  // Address behind PC_SEL_VEC; the mux lives in the fetch stage.
  localparam logic [31:0] EXC_VECTOR = 32'h0040_0004;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MD_BUSY   = 2'd1,
    EXC_FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0] pc_sel;
    logic       stall;
    logic       flush;
    logic       busy;
    logic       exc;
  } sched_out_t;

  localparam sched_out_t SCHED_IDLE = '{
    pc_sel: PC_SEL_NPC,
    stall:  1'b0,
    flush:  1'b0,
    busy:   1'b0,
    exc:    1'b0
  };

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic        en
  );
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/pc_sched_mdcnt.sv
// pc_sched_mdcnt: loadable down-counter timing the mult/div stall window.
// done flags the cycle whose decrement ends the window.
module pc_sched_mdcnt
  import pc_sched_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // Load wins over decrement; the count parks at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // A stray zero count also ends the window so the FSM cannot lock up.
  assign done = (cnt <= CNT_W'(1));

endmodule

// File: rtl/pc_sched.sv
// pc_sched: next-PC arbitration, stall/flush and mult/div window for IF.
// Optional perf counters are built when PC_SCHED_PERF_EN is defined.
module pc_sched
  import pc_sched_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_j,
  input  logic        id_jr,
  input  logic        id_br_taken,
  input  logic        id_load_use,
  input  logic        id_md_start,
  input  logic        id_exc,
  input  logic        id_eret,
  output logic [2:0]  pc_sel,
  output logic        pc_ena,
  output logic        pc_stall,
  output logic        flush_id,
  output logic        md_busy,
  output logic        exc_taken
`ifdef PC_SCHED_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_redir_cnt
`endif
);

  state_t     state_q;
  state_t     state_d;
  logic       pend_q;
  logic       pend_d;
  logic       ena_q;
  logic       md_load;
  logic       md_dec;
  logic       md_done;
  sched_out_t o;

  pc_sched_mdcnt #(
    .CNT_W(CNT_W)
  ) u_mdcnt (
    .clk      (clk),
    .rst      (rst),
    .load     (md_load),
    .dec      (md_dec),
    .load_val (CNT_W'(DIV_CYCLES - 1)),
    .done     (md_done)
  );

  // Arbitrate ID redirects and pick the next state; reset forces idle.
  always_comb begin
    o       = SCHED_IDLE;
    state_d = state_q;
    pend_d  = pend_q;
    md_load = 1'b0;
    md_dec  = 1'b0;
    case (state_q)
      RUN: begin
        if (pend_q || id_exc) begin
          o.pc_sel = PC_SEL_VEC;
          o.flush  = 1'b1;
          o.exc    = 1'b1;
          pend_d   = 1'b0;
          state_d  = EXC_FLUSH;
        end else if (id_eret) begin
          o.pc_sel = PC_SEL_ERET;
          o.flush  = 1'b1;
        end else if (id_md_start) begin
          o.stall  = 1'b1;
          o.busy   = 1'b1;
          md_load  = 1'b1;
          state_d  = MD_BUSY;
        end else if (id_load_use) begin
          o.stall  = 1'b1;
        end else if (id_jr) begin
          o.pc_sel = PC_SEL_JR;
        end else if (id_br_taken) begin
          o.pc_sel = PC_SEL_BR;
        end else if (id_j) begin
          o.pc_sel = PC_SEL_J;
        end
      end
      MD_BUSY: begin
        o.stall = 1'b1;
        o.busy  = 1'b1;
        md_dec  = 1'b1;
        if (id_exc) begin
          pend_d = 1'b1;
        end
        if (md_done) begin
          state_d = RUN;
        end
      end
      EXC_FLUSH: begin
        o.flush = 1'b1;
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
    if (!rst) begin
      o       = SCHED_IDLE;
      md_load = 1'b0;
    end
  end

  // FSM state, deferred-exception flag and PC enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
      ena_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ena_q   <= 1'b1;
    end
  end

  assign pc_sel    = o.pc_sel;
  assign pc_ena    = ena_q;
  assign pc_stall  = o.stall;
  assign flush_id  = o.flush;
  assign md_busy   = o.busy;
  assign exc_taken = o.exc;

`ifdef PC_SCHED_PERF_EN
  // Saturating event counters, live only while the PC is enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_redir_cnt <= '0;
    end else begin
      perf_stall_cnt <= sat_inc(perf_stall_cnt, ena_q & o.stall);
      perf_flush_cnt <= sat_inc(perf_flush_cnt, ena_q & o.flush);
      perf_redir_cnt <= sat_inc(perf_redir_cnt,
                                ena_q & (o.pc_sel != PC_SEL_NPC));
    end
  end
`endif

endmodule

// File: tb/tb_pc_sched.sv
// tb_pc_sched: randomized checks of pc_sched against a cycle-count model
// of the fetch scheduling rules.
module tb_pc_sched;

  localparam int DIV_CYCLES = 32;

  localparam logic [6:0] I_J    = 7'b1000000;
  localparam logic [6:0] I_JR   = 7'b0100000;
  localparam logic [6:0] I_BR   = 7'b0010000;
  localparam logic [6:0] I_LU   = 7'b0001000;
  localparam logic [6:0] I_MD   = 7'b0000100;
  localparam logic [6:0] I_EXC  = 7'b0000010;
  localparam logic [6:0] I_ERET = 7'b0000001;
  localparam logic [7:0] RST_OUT = 8'b010_00000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic id_j, id_jr, id_br_taken, id_load_use;
  logic id_md_start, id_exc, id_eret;
  logic [2:0] pc_sel;
  logic pc_ena, pc_stall, flush_id, md_busy, exc_taken;
`ifdef PC_SCHED_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_redir_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Model: remaining stall cycles, deferred exception, flush owed, enable.
  int m_busy, n_busy;
  bit m_pend, n_pend, m_flush, n_flush, m_ena;
  logic [7:0] exp_out;
  wire  [7:0] act = {pc_sel, pc_ena, pc_stall, flush_id, md_busy, exc_taken};

  always #5 clk = ~clk;

  pc_sched #(
    .DIV_CYCLES(DIV_CYCLES),
    .CNT_W(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_j        (id_j),
    .id_jr       (id_jr),
    .id_br_taken (id_br_taken),
    .id_load_use (id_load_use),
    .id_md_start (id_md_start),
    .id_exc      (id_exc),
    .id_eret     (id_eret),
    .pc_sel      (pc_sel),
    .pc_ena      (pc_ena),
    .pc_stall    (pc_stall),
    .flush_id    (flush_id),
    .md_busy     (md_busy),
    .exc_taken   (exc_taken)
`ifdef PC_SCHED_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_redir_cnt (perf_redir_cnt)
`endif
  );

  task automatic model_reset();
    m_busy = 0; m_pend = 0; m_flush = 0; m_ena = 0;
  endtask

  task automatic predict(input logic [6:0] in);
    logic [2:0] sel;
    logic st, fl, bz, et;
    sel = 3'd2; st = 0; fl = 0; bz = 0; et = 0;
    n_busy = m_busy; n_pend = m_pend; n_flush = 0;
    if (m_busy > 0) begin
      st = 1; bz = 1; n_busy = m_busy - 1;
      if (in[1]) n_pend = 1;
    end else if (m_flush) begin
      fl = 1;
    end else if (m_pend || in[1]) begin
      sel = 3'd3; fl = 1; et = 1; n_pend = 0; n_flush = 1;
    end else if (in[0]) begin
      sel = 3'd5; fl = 1;
    end else if (in[2]) begin
      st = 1; bz = 1; n_busy = DIV_CYCLES - 1;
    end else if (in[3]) begin
      st = 1;
    end else if (in[5]) begin
      sel = 3'd1;
    end else if (in[4]) begin
      sel = 3'd4;
    end else if (in[6]) begin
      sel = 3'd0;
    end
    exp_out = {sel, m_ena, st, fl, bz, et};
  endtask

  task automatic apply(input logic [6:0] in);
    {id_j, id_jr, id_br_taken, id_load_use,
     id_md_start, id_exc, id_eret} = in;
    predict(in);
  endtask

  task automatic tick();
    @(posedge clk);
    m_busy = n_busy; m_pend = n_pend; m_flush = n_flush; m_ena = 1;
    #1;
  endtask

  function automatic logic [6:0] rnd_in();
    logic [6:0] v;
    v[6] = ($urandom_range(2) == 0);
    v[5] = ($urandom_range(3) == 0);
    v[4] = ($urandom_range(2) == 0);
    v[3] = ($urandom_range(5) == 0);
    v[2] = ($urandom_range(19) == 0);
    v[1] = ($urandom_range(15) == 0);
    v[0] = ($urandom_range(15) == 0);
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      {id_j, id_jr, id_br_taken, id_load_use,
       id_md_start, id_exc, id_eret} = 7'($urandom);
      @(negedge clk); #1;
      checks++;
      if (act !== RST_OUT) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %b want %b", i, act, RST_OUT);
      end
    end
    apply(7'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (act !== RST_OUT) begin
      errors++;
      $display("FAIL reset_release: got %b want %b", act, RST_OUT);
    end
    tick();
  endtask

  task automatic test_idle();
    for (int i = 0; i < 8; i++) begin
      apply(7'd0);
      @(negedge clk);
      checks++;
      if (act !== exp_out || act !== 8'b010_10000) begin
        errors++;
        $display("FAIL idle[%0d]: got %b want %b", i, act, exp_out);
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    apply(I_J | I_JR | I_BR);
    @(negedge clk);
    checks++;
    if (act !== exp_out || pc_sel !== 3'd1 || flush_id !== 1'b0) begin
      errors++;
      $display("FAIL redir_prio: got %b want %b", act, exp_out);
    end
    tick();
    apply(I_BR);
    @(negedge clk);
    checks++;
    if (act !== exp_out || pc_sel !== 3'd4) begin
      errors++;
      $display("FAIL redir_br: got %b want %b", act, exp_out);
    end
    tick();
  endtask

  task automatic test_load_use();
    apply(I_LU | I_BR);
    @(negedge clk);
    checks++;
    if (act !== exp_out || pc_stall !== 1'b1 || pc_sel !== 3'd2) begin
      errors++;
      $display("FAIL lu_stall: got %b want %b", act, exp_out);
    end
    tick();
    apply(I_BR);
    @(negedge clk);
    checks++;
    if (act !== exp_out || pc_stall !== 1'b0 || pc_sel !== 3'd4) begin
      errors++;
      $display("FAIL lu_replay: got %b want %b", act, exp_out);
    end
    tick();
  endtask

  task automatic test_md();
    int stalls;
    int first_run;
    stalls = 0;
    first_run = -1;
    for (int i = 0; i < DIV_CYCLES + 8; i++) begin
      apply(i == 0 ? I_MD : I_J);
      @(negedge clk);
      checks++;
      if (act !== exp_out) begin
        errors++;
        $display("FAIL md[%0d]: got %b want %b", i, act, exp_out);
      end
      if (pc_stall === 1'b1 && md_busy === 1'b1) stalls++;
      if (pc_stall !== 1'b1 && first_run < 0) first_run = i;
      tick();
    end
    checks++;
    if (stalls !== DIV_CYCLES || first_run !== DIV_CYCLES) begin
      errors++;
      $display("FAIL md_window: got stalls=%0d run_at=%0d want %0d/%0d",
               stalls, first_run, DIV_CYCLES, DIV_CYCLES);
    end
  endtask

  task automatic test_md_exc();
    logic [6:0] in;
    for (int c = 1; c <= DIV_CYCLES + 2; c++) begin
      if (c == 1) in = I_MD;
      else if (c == 10) in = I_EXC;
      else in = rnd_in() & ~I_EXC;
      apply(in);
      @(negedge clk);
      checks++;
      if (act !== exp_out) begin
        errors++;
        $display("FAIL md_exc[%0d]: got %b want %b", c, act, exp_out);
      end
      if (c == DIV_CYCLES + 1) begin
        checks++;
        if (pc_sel !== 3'd3 || exc_taken !== 1'b1 || flush_id !== 1'b1) begin
          errors++;
          $display("FAIL md_exc_entry: got %b want sel=3 exc=1 flush=1", act);
        end
      end
      if (c == DIV_CYCLES + 2) begin
        checks++;
        if (flush_id !== 1'b1 || pc_sel !== 3'd2 || exc_taken !== 1'b0) begin
          errors++;
          $display("FAIL md_exc_flush: got %b want sel=2 flush=1", act);
        end
      end
      tick();
    end
  endtask

  task automatic test_exc_eret();
    apply(I_EXC | I_ERET);
    @(negedge clk);
    checks++;
    if (act !== exp_out || pc_sel !== 3'd3 || exc_taken !== 1'b1) begin
      errors++;
      $display("FAIL exc_eret: got %b want %b", act, exp_out);
    end
    tick();
    apply(7'd0);
    @(negedge clk);
    checks++;
    if (act !== exp_out) begin
      errors++;
      $display("FAIL exc_flush: got %b want %b", act, exp_out);
    end
    tick();
    apply(I_ERET);
    @(negedge clk);
    checks++;
    if (act !== exp_out || pc_sel !== 3'd5 || flush_id !== 1'b1) begin
      errors++;
      $display("FAIL eret: got %b want %b", act, exp_out);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      apply(rnd_in());
      @(negedge clk);
      checks++;
      if (act !== exp_out || pc_sel > 3'd5) begin
        errors++;
        $display("FAIL rand[%0d]: in=%b got %b want %b",
                 i, {id_j, id_jr, id_br_taken, id_load_use,
                     id_md_start, id_exc, id_eret}, act, exp_out);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_md();
    for (int i = 0; i < 5; i++) begin
      apply(i == 0 ? I_MD : I_EXC);
      @(negedge clk);
      checks++;
      if (act !== exp_out) begin
        errors++;
        $display("FAIL rst_md_pre[%0d]: got %b want %b", i, act, exp_out);
      end
      tick();
    end
    apply(I_EXC);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (act !== RST_OUT) begin
      errors++;
      $display("FAIL rst_md_async: got %b want %b", act, RST_OUT);
    end
    model_reset();
    apply(7'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (act !== exp_out) begin
      errors++;
      $display("FAIL rst_md_release: got %b want %b", act, exp_out);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      apply(7'd0);
      @(negedge clk);
      checks++;
      if (act !== exp_out || exc_taken !== 1'b0 || md_busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_md_after[%0d]: got %b want %b", i, act, exp_out);
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    {id_j, id_jr, id_br_taken, id_load_use,
     id_md_start, id_exc, id_eret} = 7'd0;
    model_reset();
    test_reset();
    test_idle();
    test_redirect();
    test_load_use();
    test_md();
    test_md_exc();
    test_exc_eret();
    test_random();
    test_reset_mid_md();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sched.md
Name: pc_sched

Overview:
- Sequencing controller for the instruction-fetch stage of the 54-instruction pipelined MIPS CPU.
- Each cycle it arbitrates redirect requests decoded in ID (jump, jr/jalr, taken branch, exception entry, eret) into the fetch stage's 3-bit next-PC select.
- It drives the fetch stage's PC enable and stall, and the ID flush.
- It owns the multicycle mult/div stall window and defers exceptions raised during that window.

Parameters:
- DIV_CYCLES, 32, cycles a mult/mul/div/divu occupies the pipeline; legal range 2..255.
- CNT_W, 8, width of the busy down-counter; must satisfy 2^CNT_W > DIV_CYCLES.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- id_j  in  1  j/jal in ID
- id_jr  in  1  jr/jalr in ID
- id_br_taken  in  1  branch in ID resolved taken
- id_load_use  in  1  load-use hazard detected in ID
- id_md_start  in  1  mult/multu/div/divu issued this cycle
- id_exc  in  1  syscall/break/teq trap in ID
- id_eret  in  1  eret in ID
- pc_sel  out  3  next-PC select: 0 jaddr, 1 raddr, 2 npc, 3 vector 0x00400004, 4 baddr, 5 eaddr (EPC); 6 and 7 are never driven
- pc_ena  out  1  PC register enable
- pc_stall  out  1  hold PC and IF/ID
- flush_id  out  1  squash the IF/ID register
- md_busy  out  1  multicycle operation in progress
- exc_taken  out  1  one-cycle pulse when the vector is selected

Behaviour:
- Reset (rst=0, asynchronous): state=RUN, counter=0, pending=0. Outputs pc_sel=2, pc_ena=0, pc_stall=0, flush_id=0, md_busy=0, exc_taken=0.
- pc_ena=1 from the first rising edge after rst deasserts.
- States: RUN, MD_BUSY, EXC_FLUSH. Outputs are combinational from state and inputs; zero added latency.
- RUN priority, highest first:
  - id_exc: pc_sel=3, flush_id=1, exc_taken=1; next state EXC_FLUSH.
  - id_eret: pc_sel=5, flush_id=1.
  - id_md_start: pc_stall=1, md_busy=1; counter<=DIV_CYCLES-1; next state MD_BUSY.
  - id_load_use: pc_stall=1 for one cycle, pc_sel=2. Any jr/br/j in the same cycle is deferred; ID re-presents it next cycle.
  - id_jr: pc_sel=1.
  - id_br_taken: pc_sel=4.
  - id_j: pc_sel=0.
  - otherwise: pc_sel=2.
- Redirects in RUN do not flush ID, because of the architectural delay slot; only exception entry and eret flush.
- MD_BUSY:
  - pc_stall=1, md_busy=1, pc_sel=2; redirect inputs are ignored.
  - Counter decrements each cycle. When counter=0, next state is RUN and stall drops that same cycle.
  - Total stalled cycles = DIV_CYCLES, counting the start cycle.
  - id_exc during MD_BUSY sets pending=1; the operation is not interruptible.
- Return from MD_BUSY with pending=1: the first RUN cycle behaves as id_exc (pc_sel=3, exc_taken=1) and clears pending, regardless of the current inputs.
- EXC_FLUSH:
  - One cycle: flush_id=1, pc_sel=2, stall=0.
  - Inputs are ignored except id_md_start and id_exc, which are also ignored because the instruction in ID is squashed.
  - Next state RUN.
- Simultaneous id_exc and id_eret: exc wins.
- id_md_start together with id_load_use: md wins; the stall subsumes the hazard.
- Reset mid-MD_BUSY: immediate return to reset values; pending is cleared.
- pc_sel never leaves the range 0..5.

Optional Feature:
- Macro PC_SCHED_PERF_EN.
- When defined, three extra outputs are added:
  - perf_stall_cnt[31:0]: cycles with pc_stall=1.
  - perf_flush_cnt[31:0]: cycles with flush_id=1.
  - perf_redir_cnt[31:0]: cycles with pc_sel not equal to 2.
- All three counters are cleared by rst, saturate at 0xFFFFFFFF, and count only while pc_ena=1.
- When not defined, the ports and logic are absent; the remaining behaviour is identical.

Decomposition:
- Shared package pc_sched_pkg holds:
  - PC_SEL_J=0, PC_SEL_JR=1, PC_SEL_NPC=2, PC_SEL_VEC=3, PC_SEL_BR=4, PC_SEL_ERET=5.
  - State encoding: RUN=2'd0, MD_BUSY=2'd1, EXC_FLUSH=2'd2.
  - EXC_VECTOR=32'h00400004 (documentation only).
- One sub-module, pc_sched_mdcnt: the loadable down-counter with a done flag.

Test Plan:
- Reset then release, all inputs 0 -> pc_ena=1 and pc_sel=2 every cycle; stall=0 and flush=0 throughout.
- id_jr=1 and id_br_taken=1 and id_j=1 in one cycle -> pc_sel=1, flush_id=0. Next cycle br only -> pc_sel=4.
- id_load_use=1 with id_br_taken=1 -> pc_stall=1, pc_sel=2. Next cycle, hazard cleared and br still taken -> pc_sel=4.
- id_md_start=1 with DIV_CYCLES=32 -> pc_stall=1 and md_busy=1 for exactly 32 cycles. id_j=1 during that window gives pc_sel=2. Cycle 33 returns to RUN.
- id_exc=1 on cycle 10 of MD_BUSY -> no effect until the window ends. First RUN cycle gives pc_sel=3, exc_taken=1, flush_id=1, followed by one EXC_FLUSH cycle with flush_id=1.
- id_exc=1 and id_eret=1 together -> pc_sel=3, exc_taken=1. Then eret alone -> pc_sel=5, flush_id=1. Assert rst=0 mid-MD_BUSY -> outputs reach reset values without waiting for a clock edge.
